mem_access_unit: RTL
====================

# mem_access_unit

Parametrised memory-access pipeline stage for the RISC-V core, sitting between the execute stage and write-back. It generalises the single-cycle word/byte memory stage to a configurable data width, byte/half/word(/double) loads and stores with sign or zero extension, byte-enable generation, misalignment detection, and a valid/ready request plus response-valid handshake to a multi-cycle data memory. The stage stalls upstream while an access is outstanding and delivers registered write-back results.

## Interface
- XLEN, 32, datapath width; 32 or 64.
- ADDR_W, 32, byte-address width.
- KEY_W, 5, register-key width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  an instruction is present in the stage input.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store; never set together with ex_mem_read.
- ex_size  in  2  access size: 0 byte, 1 half, 2 word, 3 double (legal only when XLEN=64).
- ex_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- ex_alu_result  in  XLEN  effective address for memory ops, result value otherwise.
- ex_store_data  in  XLEN  store source register value.
- ex_rd_en  in  1  instruction writes rd.
- ex_rd_key  in  KEY_W  destination register key.
- mem_stall  out  1  hold upstream stages; combinational.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 store, 0 load.
- dmem_req_addr  out  ADDR_W  address aligned down to XLEN/8 bytes.
- dmem_req_wdata  out  XLEN  lane-shifted store data.
- dmem_req_be  out  XLEN/8  byte enables.
- dmem_rsp_valid  in  1  load data valid, one cycle.
- dmem_rsp_rdata  in  XLEN  load data, full aligned word.
- wb_valid  out  1  write-back entry valid.
- wb_rd_en  out  1  write rd.
- wb_rd_key  out  KEY_W  rd key.
- wb_rd_value  out  XLEN  rd value.
- mem_misaligned  out  1  one-cycle exception pulse.

## Operation
- States IDLE, REQ, RSP. OFF = address low log2(XLEN/8) bits.
- IDLE, ex_valid, no mem op: wb_* registered from ex inputs next edge, value = ex_alu_result.
- IDLE, mem op, illegal size (3 with XLEN=32) or address not multiple of 2^size: no bus request; next edge wb_valid=1, wb_rd_en=0, mem_misaligned=1 for one cycle; stay IDLE.
- IDLE, legal mem op: capture we, addr, wdata=ex_store_data<<(8*OFF), be=((1<<2^size)-1)<<OFF, size, unsigned, OFF, rd_en, rd_key; go REQ. mem_stall=1 this cycle.
- REQ: dmem_req_valid=1, payload stable until ready. On ready: store → wb_valid=1, wb_rd_en=0 next edge, go IDLE; load → go RSP. Stall=1 except a store accepted this cycle (stall=0).
- RSP: wait dmem_rsp_valid; stall=1 except in the rsp cycle (0). On rsp: wb_rd_value=extend((rdata>>8*OFF) truncated to 2^size bytes), wb_rd_en=captured rd_en, wb_valid=1; go IDLE.
- Sign extension from the top bit of the selected field; zero when unsigned; word loads on XLEN=64 extend from bit 31.
- Otherwise wb_valid=0 and mem_misaligned=0 each cycle.
- Responses in IDLE/REQ are ignored.

## Timing
- Reset: state IDLE; dmem_req_valid, dmem_req_we, wb_valid, wb_rd_en, mem_misaligned = 0; dmem_req_addr, wdata, be, wb_rd_key, wb_rd_value = 0.
- Reset mid-REQ/RSP: abandon access, IDLE, no write-back; a late response is ignored.
- Non-memory and misaligned: 1-cycle latency, no stall.
- Store: minimum 2 cycles (IDLE, REQ with ready); wb at end of REQ.
- Load: minimum 3 cycles (IDLE, REQ, RSP with rsp_valid); wb registered at end of the RSP cycle.
- Upstream holds ex_* stable while mem_stall=1; a new instruction is taken in the cycle stall drops only by the next IDLE.

## Test plan
- Reset during RSP, then rsp_valid → no wb_valid, dmem_req_valid=0, state IDLE.
- ALU op ex_alu_result=0x1234, rd_key=5 → next cycle wb_valid=1, wb_rd_value=0x1234, wb_rd_key=5, mem_stall never high.
- SB addr 0x103, data 0xAB, ready immediate → dmem_req_addr=0x100, be=0b1000, wdata=0xAB000000; stall high 1 cycle; wb_rd_en=0.
- LH signed addr 0x202, rdata 0x8001_0000, rsp 3 cycles late → wb_rd_value=0xFFFF8001; LHU same → 0x00008001; stall held throughout wait.
- LW addr 0x301 → no request, mem_misaligned pulse, wb_rd_en=0; XLEN=32 size 3 → same.
- dmem_req_ready low 4 cycles → req payload stable, stall high; XLEN=64 LD addr 0x8 → be=0xFF, full 64-bit value.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Issues byte/half/word(/double) loads and stores to a multi-cycle
//            data memory over a valid/ready request channel and a one-cycle
//            response-valid channel. Generates byte enables and lane-shifted
//            store data, sign/zero-extends load data, flags misaligned or
//            illegal-size accesses, and stalls upstream while an access is
//            outstanding. All write-back outputs are registered.
// Ports    : clk/reset         - clock, asynchronous active-high reset
//            ex_*              - instruction from execute stage
//            mem_stall         - combinational upstream hold
//            dmem_req_*        - request channel to data memory
//            dmem_rsp_*        - load response from data memory
//            wb_*              - registered write-back entry
//            mem_misaligned    - one-cycle exception pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int KEY_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic [1:0]           ex_size,
    input  logic                 ex_unsigned,
    input  logic [XLEN-1:0]      ex_alu_result,
    input  logic [XLEN-1:0]      ex_store_data,
    input  logic                 ex_rd_en,
    input  logic [KEY_W-1:0]     ex_rd_key,
    output logic                 mem_stall,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic                 dmem_req_we,
    output logic [ADDR_W-1:0]    dmem_req_addr,
    output logic [XLEN-1:0]      dmem_req_wdata,
    output logic [XLEN/8-1:0]    dmem_req_be,
    input  logic                 dmem_rsp_valid,
    input  logic [XLEN-1:0]      dmem_rsp_rdata,
    output logic                 wb_valid,
    output logic                 wb_rd_en,
    output logic [KEY_W-1:0]     wb_rd_key,
    output logic [XLEN-1:0]      wb_rd_value,
    output logic                 mem_misaligned
);

    localparam int c_BYTES = XLEN / 8;
    localparam int c_OFF_W = $clog2(c_BYTES);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(c_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [c_OFF_W-1:0]     r_off;
    logic                   r_rd_en;
    logic [KEY_W-1:0]       r_rd_key;

    // ------------------------------------------------------------------
    // Request-side decode (from ex_* inputs)
    // ------------------------------------------------------------------
    logic                   w_mem_op;
    logic [c_OFF_W-1:0]     w_off;
    logic [3:0]             w_align_full;
    logic [c_OFF_W-1:0]     w_align_mask;
    logic                   w_illegal_size;
    logic                   w_misaligned;
    logic [ADDR_W-1:0]      w_addr_full;
    logic [c_BYTES-1:0]     w_be_base;
    logic [c_BYTES-1:0]     w_be;
    logic [XLEN-1:0]        w_wdata;

    generate
        if (ADDR_W <= XLEN) begin : g_addr_trunc
            assign w_addr_full = ex_alu_result[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign w_addr_full = {{(ADDR_W-XLEN){1'b0}}, ex_alu_result};
        end
    endgenerate

    always_comb begin
        w_mem_op       = ex_mem_read | ex_mem_write;
        w_off          = ex_alu_result[c_OFF_W-1:0];
        // Low address bits that must be zero for a naturally aligned access.
        w_align_full   = ~(4'hF << ex_size);
        w_align_mask   = w_align_full[c_OFF_W-1:0];
        w_illegal_size = (ex_size == 2'd3) && (XLEN != 64);
        w_misaligned   = w_illegal_size || (|(w_off & w_align_mask));
        // 2^size contiguous ones; a full-width shift yields an all-ones mask.
        w_be_base      = ~({c_BYTES{1'b1}} << (4'd1 << ex_size));
        w_be           = w_be_base << w_off;
        w_wdata        = ex_store_data << {w_off, 3'b000};
    end

    // ------------------------------------------------------------------
    // Load extraction and extension (from captured access attributes)
    // ------------------------------------------------------------------
    logic [XLEN-1:0]        w_rsp_shifted;
    logic [7:0]             w_nbits;
    logic [XLEN-1:0]        w_field_mask;
    logic                   w_sign;
    logic [XLEN-1:0]        w_load_value;

    always_comb begin
        w_rsp_shifted = dmem_rsp_rdata >> {r_off, 3'b000};
        w_nbits       = 8'd8 << r_size;
        w_field_mask  = ~({XLEN{1'b1}} << w_nbits);
        // Topmost set bit of the field mask selects the sign bit.
        w_sign        = ~r_unsigned &
                        (|(w_rsp_shifted & w_field_mask & ~(w_field_mask >> 1)));
        w_load_value  = (w_rsp_shifted & w_field_mask) |
                        ({XLEN{w_sign}} & ~w_field_mask);
    end

    // ------------------------------------------------------------------
    // Upstream stall: released in the cycle the access completes so the
    // next instruction is presented as the stage returns to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        mem_stall = 1'b0;
        case (r_state)
            ST_IDLE: mem_stall = ex_valid && w_mem_op && !w_misaligned;
            ST_REQ:  mem_stall = !(dmem_req_ready && dmem_req_we);
            ST_RSP:  mem_stall = !dmem_rsp_valid;
            default: mem_stall = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered bus and write-back outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_off          <= '0;
            r_rd_en        <= 1'b0;
            r_rd_key       <= '0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_be    <= '0;
            wb_valid       <= 1'b0;
            wb_rd_en       <= 1'b0;
            wb_rd_key      <= '0;
            wb_rd_value    <= '0;
            mem_misaligned <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            mem_misaligned <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (!w_mem_op) begin
                            wb_valid    <= 1'b1;
                            wb_rd_en    <= ex_rd_en;
                            wb_rd_key   <= ex_rd_key;
                            wb_rd_value <= ex_alu_result;
                        end else if (w_misaligned) begin
                            wb_valid       <= 1'b1;
                            wb_rd_en       <= 1'b0;
                            wb_rd_key      <= ex_rd_key;
                            mem_misaligned <= 1'b1;
                        end else begin
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= ex_mem_write;
                            dmem_req_addr  <= w_addr_full & c_ALIGN_MASK;
                            dmem_req_wdata <= w_wdata;
                            dmem_req_be    <= w_be;
                            r_size         <= ex_size;
                            r_unsigned     <= ex_unsigned;
                            r_off          <= w_off;
                            r_rd_en        <= ex_rd_en;
                            r_rd_key       <= ex_rd_key;
                            r_state        <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        if (dmem_req_we) begin
                            wb_valid  <= 1'b1;
                            wb_rd_en  <= 1'b0;
                            wb_rd_key <= r_rd_key;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_state   <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_valid    <= 1'b1;
                        wb_rd_en    <= r_rd_en;
                        wb_rd_key   <= r_rd_key;
                        wb_rd_value <= w_load_value;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
